bsu_merge8: RTL
===============

# bsu_merge8

Downstream merge stage for the 4-input bitonic sort unit. It accepts two ascending-sorted 4-element groups of 6-bit keys through a valid/ready handshake and buffers them. It then streams their 8-element ascending merge, one key per cycle. It forms the second level of the hybrid sorter: parallel bitonic sort of 4-element chunks, then sequential merge into 8-element runs.

## Interface
Parameters:
- DW, 6, key width in bits; must match the bitonic sort unit data width.

Ports:
- clk  input  1  rising-edge clock; one clock domain only.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a sorted group is present on in1..in4.
- in_ready  output  1  block can accept a group this cycle.
- in1, in2, in3, in4  input  DW each  sorted group, ascending; in1 is the smallest.
- out_valid  output  1  out_data holds a merged key.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  DW  merged key.
- out_src  output  1  source of out_data: 0 = group A, 1 = group B.
- out_last  output  1  marks the 8th key of the run.
- busy  output  1  high in ST_LOAD_B and ST_MERGE.
- err_unsorted  output  1  sticky flag set on an unsorted input group.

## Operation
- Groups and registers:
  - First accepted group is A; it goes into regs a[0..3].
  - Second accepted group is B; it goes into regs b[0..3].
  - Read pointers ia and ib are 3 bits each, range 0..4.
- A transfer occurs when valid and ready are both high on a rising clk edge, on either interface.
- State machine:
  - ST_LOAD_A: in_ready=1. On transfer, capture A and go to ST_LOAD_B.
  - ST_LOAD_B: in_ready=1. On transfer, capture B, clear ia and ib, go to ST_MERGE.
  - ST_MERGE: in_ready=0, out_valid=1.
    - Selection: if ia==4, take b[ib]. Else if ib==4, take a[ia]. Else take a[ia] when a[ia] <= b[ib], otherwise b[ib].
    - Ties resolve to A, so the merge is stable.
    - out_data and out_src are the selected key and its source.
    - On each output transfer, increment the selected pointer.
    - out_last = (ia+ib == 7).
    - A transfer with out_last=1 returns the block to ST_LOAD_A.
- Arithmetic:
  - Comparison is unsigned, full DW width.
  - Pointers never exceed 4. Selection for an exhausted side is never evaluated.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_src, out_last and both pointers hold.
- The block never drops an accepted group and never emits more than 8 keys per run.
- Reset, at any point including mid-merge:
  - Enters ST_LOAD_A.
  - in_ready=1 after reset deasserts.
  - out_valid=0, out_data=0, out_src=0, out_last=0, busy=0, err_unsorted=0.
  - Pointers=0; a and b regs=0.
  - Any partial run is discarded.
- Input data is ignored when in_valid=0 or in_ready=0.

## Timing
- in_ready is a function of state only. It has no combinational path from in_valid or out_ready.
- out_valid, out_data, out_src and out_last come from registered state and pointers through the compare mux. They have no combinational path from in_*.
- Latency: B accepted at edge N gives first out_valid=1 in the cycle after edge N.
- After the out_last transfer at edge M, in_ready=1 in the cycle after edge M.
- Minimum period per run is 10 cycles: 2 load + 8 merge, with in_valid and out_ready held high.
- No input/output overlap. An in_valid asserted during ST_MERGE waits, with no loss.

## Configuration
- MERGE_SORT_CHECK_EN
  - Defined: each accepted group is checked for in1<=in2<=in3<=in4. A violation sets err_unsorted=1 on the accepting edge. The flag stays set until reset. Merge proceeds unchanged; output order is then undefined, but exactly 8 keys are still emitted.
  - Undefined: no check logic; err_unsorted is tied to 0.

## Test plan
- Basic merge: A={1,5,9,13}, B={2,3,10,63}, out_ready=1 → out_data 1,2,3,5,9,10,13,63; out_src 0,1,1,0,0,1,0,1; out_last only on 63; first key in the cycle after B is accepted.
- Ties and stability: A={7,7,7,7}, B={7,7,7,7} → eight 7s, out_src 0,0,0,0,1,1,1,1.
- Exhaustion: A={0,1,2,3}, B={60,61,62,63} → A drains first, then B streams; ia stays at 4 and is never indexed. Swapped order, A={60..63}, B={0..3} → B keys first, out_src 1,1,1,1,0,0,0,0.
- Backpressure: same run as the basic merge, out_ready toggled 1,0,0,1,... → outputs held stable while stalled; same 8-key sequence; in_ready stays 0 until the out_last transfer; in_valid held high during ST_MERGE is not accepted.
- Reset mid-merge: assert rst_n=0 after 3 output keys → outputs go to reset values immediately. Then a new A/B pair merges correctly with no residue from the aborted run.
- Check option: with MERGE_SORT_CHECK_EN, A={5,4,8,9} → err_unsorted=1 from the accept edge, 8 keys still emitted, flag persists. Without the macro → err_unsorted stays 0.

Source files
------------

// File: rtl/bsu_merge8.sv
`default_nettype none
// ============================================================================
// Module      : bsu_merge8
// Description : Second-level merge stage of the hybrid sorter. Buffers two
//               ascending 4-key groups (A then B) and streams their stable
//               8-key ascending merge, one key per output transfer.
//               Optional feature macro: MERGE_SORT_CHECK_EN (sticky check
//               that every accepted group is ascending).
// Revision    : 1.0 - initial release
// ============================================================================
module bsu_merge8 #(
    parameter int DW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    input  logic [DW-1:0] in4,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_src,
    output logic          out_last,
    output logic          busy,
    output logic          err_unsorted
);

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_MERGE  = 2'd2
    } state_t;

    localparam logic [2:0] c_ptr_end = 3'd4;
    localparam logic [3:0] c_last_sum = 4'd7;

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_a [4];
    logic [DW-1:0] r_b [4];
    logic [2:0]    r_ia;
    logic [2:0]    r_ib;

    logic [DW-1:0] w_a_key;
    logic [DW-1:0] w_b_key;
    logic          w_take_b;
    logic          w_last;
    logic [3:0]    w_sum;

    // Heads of both groups; an exhausted pointer (4) aliases entry 0 but the
    // selection below never picks that side, so the aliased value is unused.
    assign w_a_key = r_a[r_ia[1:0]];
    assign w_b_key = r_b[r_ib[1:0]];

    // Ties go to A, which keeps the merge stable.
    assign w_take_b = (r_ia == c_ptr_end) ? 1'b1 :
                      (r_ib == c_ptr_end) ? 1'b0 :
                      (w_a_key > w_b_key);

    assign w_sum  = {1'b0, r_ia} + {1'b0, r_ib};
    assign w_last = (w_sum == c_last_sum);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD_A;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake/output decode; outputs depend only on state,
    // pointers and buffered keys, never on in_* or out_ready.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_src   = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    w_next = ST_MERGE;
                end
            end
            ST_MERGE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = w_take_b ? w_b_key : w_a_key;
                out_src   = w_take_b;
                out_last  = w_last;
                if (out_ready && w_last) begin
                    w_next = ST_LOAD_A;
                end
            end
            default: begin
                w_next = ST_LOAD_A;
            end
        endcase
    end

    // Group capture and read-pointer advance; all hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
            r_ia <= '0;
            r_ib <= '0;
        end else begin
            case (r_state)
                ST_LOAD_A: begin
                    if (in_valid) begin
                        r_a[0] <= in1;
                        r_a[1] <= in2;
                        r_a[2] <= in3;
                        r_a[3] <= in4;
                    end
                end
                ST_LOAD_B: begin
                    if (in_valid) begin
                        r_b[0] <= in1;
                        r_b[1] <= in2;
                        r_b[2] <= in3;
                        r_b[3] <= in4;
                        r_ia   <= '0;
                        r_ib   <= '0;
                    end
                end
                ST_MERGE: begin
                    if (out_ready) begin
                        if (w_take_b) begin
                            r_ib <= r_ib + 3'd1;
                        end else begin
                            r_ia <= r_ia + 3'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MERGE_SORT_CHECK_EN
    logic r_err;
    logic w_unsorted;

    assign w_unsorted = (in1 > in2) || (in2 > in3) || (in3 > in4);

    // Sticky flag: set on the edge that accepts an out-of-order group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (in_valid && in_ready && w_unsorted) begin
            r_err <= 1'b1;
        end
    end

    assign err_unsorted = r_err;
`else
    assign err_unsorted = 1'b0;
`endif

endmodule
`default_nettype wire
